// File: rtl/fft_pkg.sv
// Shared defaults, read-FSM encoding and index bit reversal for the FFT
// output reorder buffer.
package fft_pkg;

    localparam int unsigned N_PTS_DEF = 8;
    localparam int unsigned LOG2N_DEF = 3;
    localparam int unsigned DW_DEF    = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Reverse the low 'width' bits of idx; upper result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r[5'(i)] = idx[5'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_bank.sv
// Ping-pong storage: two N_PTS x DW register banks.
// Ports: clk; write port i_wr_en/i_wr_bank/i_wr_addr/i_wr_data (synchronous);
//        read port i_rd_bank/i_rd_addr -> o_rd_data_c (combinational).
// Contents are deliberately not reset.
module pingpong_bank
    import fft_pkg::*;
#(
    parameter int unsigned N_PTS = N_PTS_DEF,
    parameter int unsigned LOG2N = LOG2N_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic             i_wr_bank,
    input  logic [LOG2N-1:0] i_wr_addr,
    input  logic [DW-1:0]    i_wr_data,
    input  logic             i_rd_bank,
    input  logic [LOG2N-1:0] i_rd_addr,
    output logic [DW-1:0]    o_rd_data_c
);

    logic [DW-1:0] r_mem [2][N_PTS];

    // Single write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    // Combinational read port
    assign o_rd_data_c = r_mem[i_rd_bank][i_rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer behind the last SDF stage.
// Ports: clk, clear (async active-high reset);
//        in_valid/in_data   : push-only input stream, bit-reversed order;
//        out_valid/out_ready/out_data/out_last : natural-order output stream;
//        overflow           : sticky, set when an input sample is dropped.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N_PTS = N_PTS_DEF,
    parameter int unsigned LOG2N = LOG2N_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          overflow
);

    localparam int unsigned      RCW      = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_PTS - 1);
    localparam logic [RCW-1:0]   RC_END   = RCW'(N_PTS);

    logic [LOG2N-1:0] r_wcnt;
    logic             r_wbank;
    logic             r_overflow;
    logic [1:0]       r_full;
    rd_state_e        r_state;
    logic             r_rbank;
    logic [RCW-1:0]   r_rcnt;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;
    logic             r_out_last;

    logic             w_wr_en;
    logic             w_wr_end;
    logic [LOG2N-1:0] w_wr_addr;
    logic             w_take;
    logic             w_last_acc;
    logic             w_can_load;
    logic             w_src_ok;
    logic             w_load;
    logic             w_rd_bank;
    logic [LOG2N-1:0] w_rd_addr;
    logic [DW-1:0]    w_rd_data;
    rd_state_e        w_state_nxt;
    logic             w_rbank_nxt;
    logic [RCW-1:0]   w_rcnt_nxt;
    logic [1:0]       w_full_nxt;
    logic             w_ov_nxt;
    logic [DW-1:0]    w_od_nxt;
    logic             w_ol_nxt;

    pingpong_bank #(
        .N_PTS (N_PTS),
        .LOG2N (LOG2N),
        .DW    (DW)
    ) u_bank (
        .clk         (clk),
        .i_wr_en     (w_wr_en),
        .i_wr_bank   (r_wbank),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   (in_data),
        .i_rd_bank   (w_rd_bank),
        .i_rd_addr   (w_rd_addr),
        .o_rd_data_c (w_rd_data)
    );

    // Writer stores sample k at bitrev(k); a full target bank drops the sample
    assign w_wr_en   = in_valid & ~r_full[r_wbank];
    assign w_wr_end  = w_wr_en & (r_wcnt == LAST_IDX);
    assign w_wr_addr = LOG2N'(bitrev(32'(r_wcnt), LOG2N));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_wcnt     <= '0;
            r_wbank    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wcnt <= r_wcnt + LOG2N'(1);
                if (w_wr_end) begin
                    r_wbank <= ~r_wbank;
                end
            end
            if (in_valid && r_full[r_wbank]) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_take     = r_out_valid & out_ready;
    assign w_last_acc = w_take & r_out_last;
    assign w_can_load = ~r_out_valid | out_ready;

    // Read FSM, bank flags and output-register next state
    always_comb begin
        w_state_nxt = r_state;
        w_rbank_nxt = r_rbank;
        w_rcnt_nxt  = r_rcnt;
        w_full_nxt  = r_full;
        w_rd_bank   = r_rbank;
        w_rd_addr   = r_rcnt[LOG2N-1:0];
        w_src_ok    = 1'b0;
        w_load      = 1'b0;
        w_ov_nxt    = r_out_valid;
        w_od_nxt    = r_out_data;
        w_ol_nxt    = r_out_last;

        case (r_state)
            IDLE: begin
                // Word 0 is loaded on the same edge the FSM leaves IDLE
                w_rd_addr = '0;
                w_src_ok  = r_full[r_rbank];
            end
            STREAM: begin
                if (w_last_acc) begin
                    // Frame done: switch banks and pull word 0 of the other
                    // bank in the same cycle if it is already complete
                    w_rbank_nxt = ~r_rbank;
                    w_rcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                    w_rd_bank   = ~r_rbank;
                    w_rd_addr   = '0;
                    w_src_ok    = r_full[~r_rbank];
                end else begin
                    w_src_ok = (r_rcnt < RC_END);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_load = w_src_ok & w_can_load;

        if (w_load) begin
            w_state_nxt = STREAM;
            w_rcnt_nxt  = RCW'(w_rd_addr) + RCW'(1);
            w_ov_nxt    = 1'b1;
            w_od_nxt    = w_rd_data;
            w_ol_nxt    = (w_rd_addr == LAST_IDX);
        end else if (w_take) begin
            w_ov_nxt = 1'b0;
        end

        // Set and clear always target different banks
        if (w_wr_end) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_last_acc) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state     <= IDLE;
            r_rbank     <= 1'b0;
            r_rcnt      <= '0;
            r_full      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rbank     <= w_rbank_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_full      <= w_full_nxt;
            r_out_valid <= w_ov_nxt;
            r_out_data  <= w_od_nxt;
            r_out_last  <= w_ol_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

endmodule
